// File: rtl/alu_share_pkg.sv
// alu_share_pkg
// Shared definitions for the ALU-sharing scheduler: FSM state encoding,
// requester count and statistics counter width.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned STATS_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin arbiter.
// Ports:
//   req_valid_i  - per-requester valid
//   last_grant_i - requester granted most recently (register owned by caller)
//   grant_o      - one-hot grant, all zero when nobody is valid
//   winner_o     - index of the granted requester (meaningful when any_o=1)
//   any_o        - at least one requester valid
module rr_arb2
    import alu_share_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               winner_o,
    output logic               any_o
);

    always_comb begin
        any_o = |req_valid_i;
        // Contention goes to whoever did not win last; otherwise the sole
        // valid requester wins (bit 1 set means requester 1 is the only one).
        if (&req_valid_i) begin
            winner_o = ~last_grant_i;
        end else begin
            winner_o = req_valid_i[1];
        end
        if (any_o) begin
            grant_o = winner_o ? 2'b10 : 2'b01;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// alu_share_sched
// Shares one external combinational two-operand unit between two requesters.
// A round-robin winner is accepted in IDLE, its operands are registered onto
// the unit inputs, the unit result is captured one cycle later and returned
// over a valid/ready response channel together with the requester id.
//
// Optional feature macro: SCHED_STATS_EN adds saturating 8-bit per-requester
// grant counters on outputs grant_cnt0 / grant_cnt1.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_valid/req_ready     - per-requester request handshake
//   req_a/req_b/req_sel     - packed per-requester operands and select
//   unit_a/unit_b/unit_sel  - registered drive to the shared unit
//   unit_out/unit_carry     - shared unit result
//   rsp_valid/rsp_ready     - response handshake
//   rsp_data/rsp_carry/rsp_id - captured result, carry and issuing requester
module alu_share_sched
    import alu_share_pkg::*;
#(
    parameter int unsigned N_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*N_BITS-1:0]     req_a,
    input  logic [NUM_REQ*N_BITS-1:0]     req_b,
    input  logic [NUM_REQ-1:0]            req_sel,
    output logic [N_BITS-1:0]             unit_a,
    output logic [N_BITS-1:0]             unit_b,
    output logic                          unit_sel,
    input  logic [N_BITS-1:0]             unit_out,
    input  logic                          unit_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [N_BITS-1:0]             rsp_data,
    output logic                          rsp_carry,
    output logic                          rsp_id
`ifdef SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0]            grant_cnt0,
    output logic [STATS_W-1:0]            grant_cnt1
`endif
);

    state_e              state_q, state_d;
    logic [N_BITS-1:0]   unit_a_q, unit_a_d;
    logic [N_BITS-1:0]   unit_b_q, unit_b_d;
    logic                unit_sel_q, unit_sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [N_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic                id_q, id_d;
    logic                last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]  grant;
    logic                winner;
    logic                any_req;
    logic [NUM_REQ-1:0]  accept;

    rr_arb2 u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .winner_o     (winner),
        .any_o        (any_req)
    );

    // Grants are only offered while no operation is in flight.
    assign accept    = (state_q == IDLE) ? grant : '0;
    assign req_ready = accept;

    always_comb begin
        state_d      = state_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        unit_sel_d   = unit_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    unit_a_d     = winner ? req_a[2*N_BITS-1:N_BITS] : req_a[N_BITS-1:0];
                    unit_b_d     = winner ? req_b[2*N_BITS-1:N_BITS] : req_b[N_BITS-1:0];
                    unit_sel_d   = winner ? req_sel[1] : req_sel[0];
                    id_d         = winner;
                    last_grant_d = winner;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                rsp_data_d  = unit_out;
                rsp_carry_d = unit_carry;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            unit_sel_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            unit_sel_q   <= unit_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign unit_a    = unit_a_q;
    assign unit_b    = unit_b_q;
    assign unit_sel  = unit_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = id_q;

`ifdef SCHED_STATS_EN
    logic [STATS_W-1:0] cnt0_q, cnt0_d;
    logic [STATS_W-1:0] cnt1_q, cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept[0] && (cnt0_q != '1)) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (accept[1] && (cnt1_q != '1)) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Scheduler that shares one combinational two-operand unit (N_BITS-wide operands `a`, `b`, 1-bit operation `select`, outputs `out` and `carry_out`) between two requesters. Each requester submits an operation over a valid/ready handshake. The block arbitrates round-robin, drives the unit from registered operands, and captures the result one cycle later. It returns the result, carry and requester ID over a response valid/ready handshake. It sits between the requesting logic and the shared unit, and is the only driver of the unit's inputs.

## Interface
- N_BITS, 4, operand/result width (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req_a  in  2*N_BITS  operand a; requester i uses bits [i*N_BITS +: N_BITS]
- req_b  in  2*N_BITS  operand b; same packing
- req_sel  in  2  operation select per requester
- unit_a  out  N_BITS  registered operand to shared unit
- unit_b  out  N_BITS  registered operand to shared unit
- unit_sel  out  1  registered select to shared unit
- unit_out  in  N_BITS  shared unit result
- unit_carry  in  1  shared unit carry_out
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  N_BITS  captured result
- rsp_carry  out  1  captured carry
- rsp_id  out  1  requester that issued the operation

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If any req_valid is set, the round-robin winner is granted. req_ready[winner]=1 combinationally in IDLE only.
  - On the clock edge, the winner's a/b/sel load into unit_a/unit_b/unit_sel and winner loads into the id register. Next state: SETTLE.
- SETTLE:
  - The unit inputs are stable for one full cycle.
  - On the edge, unit_out→rsp_data, unit_carry→rsp_carry, and rsp_valid←1. Next state: RESP.
- RESP:
  - Holds rsp_valid and all rsp_* fields stable until rsp_ready=1.
  - On the accepting edge, rsp_valid←0. Next state: IDLE.
- Round-robin:
  - The last_grant register starts at 1, so requester 0 wins first after reset.
  - When both requesters are valid, the grant goes to the requester that is not last_grant.
  - When only one is valid, that one wins. last_grant updates only on a grant.
- Requester rules:
  - A requester must hold valid and operands until its ready is seen.
  - req_valid that drops without acceptance is simply ignored.
- req_ready is 0 in SETTLE and RESP. No requests are accepted while an operation is in flight.
- unit_a/unit_b/unit_sel hold their last value outside a grant. They are not cleared after the response.
- Reset values: state=IDLE, unit_a=0, unit_b=0, unit_sel=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, last_grant=1, req_ready=0 (combinational, valid-gated).
- Reset asserted mid-operation aborts immediately: an in-flight operation is lost and no response is produced.

## Timing
- Accept edge T0 → unit inputs valid after T0 → result captured at T1 → rsp_valid=1 from after T1.
- Minimum issue-to-issue spacing is 3 cycles: IDLE, SETTLE, RESP with rsp_ready=1.
- rsp_ready held high in RESP gives a 1-cycle response. Backpressure extends RESP indefinitely.
- rsp_ready while rsp_valid=0 is ignored.
- The shared unit's combinational path must settle within one clock period from registered inputs.

## Configuration
- SCHED_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each an 8-bit out.
  - Each counter increments on that requester's accepting edge and saturates at 255.
  - Reset value is 0.
- SCHED_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `alu_share_pkg`:
  - FSM state enum: IDLE=2'd0, SETTLE=2'd1, RESP=2'd2.
  - Requester count constant NUM_REQ=2.
  - Counter width constant STATS_W=8.
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin grant from req_valid and last_grant.
  - Produces a one-hot grant and a winner index.
  - The top level owns the last_grant register.

## Test plan
- Reset → all outputs zero, req_ready=0; releasing rst_n with req_valid=2'b01 → req_ready=2'b01 in the same cycle.
- N_BITS=4, requester 0: a=4'd9, b=4'd8, sel=0 → unit_a=9, unit_b=8 one cycle after accept; rsp_data/rsp_carry equal the unit outputs, rsp_id=0, rsp_valid two edges after accept.
- Both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; new accept every 3 cycles.
- rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req_ready=2'b00 throughout, and requester 1 is not accepted until after the response.
- rst_n pulsed low during SETTLE → rsp_valid never rises for that operation; state returns to IDLE; next grant goes to requester 0.
- With SCHED_STATS_EN: 300 grants to requester 0 → grant_cnt0=255 and grant_cnt1 unchanged.
